// File: rtl/shiftreg_seq_ctrl.sv
// shiftreg_seq_ctrl: sequences one load-then-shift-right job on an external
// 4-bit shift register and returns its contents over a valid/ready handshake.
module shiftreg_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [WIDTH-1:0] job_num,
    input  logic [AMT_W-1:0] job_amt,
    input  logic             job_mode,
    input  logic             job_fill,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             sr_load,
    output logic [WIDTH-1:0] sr_num,
    output logic             sr_ctrl,
    output logic             sr_incoming,
    input  logic [WIDTH-1:0] sr_out
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [AMT_W-1:0] amt, cnt;
    logic mode, fill;
    logic accept, last_shift;
    always_comb begin
        state_nx    = state;
        job_ready   = 1'b0;
        res_valid   = 1'b0;
        sr_ctrl     = 1'b0;
        sr_incoming = 1'b0;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                state_nx  = job_valid ? LOAD : IDLE;
            end
            LOAD: state_nx = (amt == '0) ? DONE : SHIFT;
            SHIFT: begin
                sr_ctrl     = 1'b1;
                sr_incoming = mode ? sr_out[0] : fill;
                state_nx    = (cnt == AMT_W'(1)) ? DONE : SHIFT;
            end
            DONE: begin
                res_valid = 1'b1;
                state_nx  = res_ready ? IDLE : DONE;
            end
            default: state_nx = IDLE;
        endcase
    end
    assign accept     = (state == IDLE) && job_valid;
    assign last_shift = (state == SHIFT) && (cnt == AMT_W'(1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr_load  <= 1'b0;
            sr_num   <= '0;
            amt      <= '0;
            mode     <= 1'b0;
            fill     <= 1'b0;
            cnt      <= '0;
            res_data <= '0;
        end else begin
            state   <= state_nx;
            sr_load <= accept;
            if (accept) begin
                sr_num <= job_num;
                amt    <= job_amt;
                mode   <= job_mode;
                fill   <= job_fill;
            end
            if (state == LOAD)
                cnt <= amt;
            else if (state == SHIFT)
                cnt <= cnt - AMT_W'(1);
            // The register takes its final shift on this same edge, so capture the shifted value.
            if ((state == LOAD) && (amt == '0))
                res_data <= sr_out;
            else if (last_shift)
                res_data <= {sr_incoming, sr_out[WIDTH-1:1]};
        end
    end
endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// tb_shiftreg_seq_ctrl: drives directed and random jobs through the sequencer and an
// in-bench shift register, comparing every cycle against a job-timeline model.
module tb_shiftreg_seq_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic job_valid = 1'b0, job_mode = 1'b0, job_fill = 1'b0, res_ready = 1'b0;
    logic [3:0] job_num = 4'd0;
    logic [2:0] job_amt = 3'd0;
    logic job_ready, res_valid, sr_load, sr_ctrl, sr_incoming;
    logic [3:0] res_data, sr_num, sr_out;
    logic [3:0] sr_q = 4'd0;
    int checks = 0, errors = 0;

    int m_k = 0, m_amt = 0;
    logic [3:0] m_num = 4'd0, m_res = 4'd0;
    logic m_mode = 1'b0, m_fill = 1'b0;

    always #5 clk = ~clk;

    shiftreg_seq_ctrl #(.WIDTH(4), .AMT_W(3)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_num(job_num), .job_amt(job_amt), .job_mode(job_mode), .job_fill(job_fill),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .sr_load(sr_load), .sr_num(sr_num), .sr_ctrl(sr_ctrl),
        .sr_incoming(sr_incoming), .sr_out(sr_out)
    );

    // The controlled register: async load, shift right with serial input at the MSB.
    always @(posedge clk or posedge sr_load)
        if (sr_load) sr_q <= sr_num;
        else if (sr_ctrl) sr_q <= {sr_incoming, sr_q[3:1]};
    assign sr_out = sr_q;

    function automatic logic [3:0] exp_res(logic [3:0] num, int amt, logic mode, logic fill);
        logic [7:0] d;
        logic [3:0] f, r;
        if (mode) begin
            d = {num, num} >> (amt % 4);
            return d[3:0];
        end
        if (amt >= 4) return {4{fill}};
        f = fill ? 4'hF : 4'h0;
        r = (num >> amt) | (f << (4 - amt));
        return r;
    endfunction

    // Timeline model: m_k counts cycles since acceptance (1 = load cycle), 0 = idle.
    always @(posedge clk or posedge rst)
        if (rst) begin
            m_k   <= 0;
            m_num <= 4'd0;
            m_amt <= 0;
        end else if (m_k == 0) begin
            if (job_valid) begin
                m_k    <= 1;
                m_num  <= job_num;
                m_amt  <= int'(job_amt);
                m_mode <= job_mode;
                m_fill <= job_fill;
                m_res  <= exp_res(job_num, int'(job_amt), job_mode, job_fill);
            end
        end else if (m_k < 2 + m_amt) m_k <= m_k + 1;
        else if (res_ready) m_k <= 0;

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic shifting;
        shifting = m_k >= 2 && m_k <= 1 + m_amt;
        chk("job_ready", {3'b0, job_ready}, {3'b0, m_k == 0});
        chk("sr_load", {3'b0, sr_load}, {3'b0, m_k == 1});
        chk("sr_ctrl", {3'b0, sr_ctrl}, {3'b0, shifting});
        chk("res_valid", {3'b0, res_valid}, {3'b0, m_k >= 2 + m_amt});
        chk("sr_incoming", {3'b0, sr_incoming}, {3'b0, shifting && (m_mode ? sr_q[0] : m_fill)});
        chk("sr_num", sr_num, m_num);
        if (m_k >= 2 + m_amt) chk("res_data", res_data, m_res);
    end

    task automatic do_job(logic [3:0] num, int amt, logic mode, logic fill, int hold,
                          logic pulse, output logic [3:0] got);
        int n;
        @(posedge clk); #1;
        job_num = num; job_amt = 3'(amt); job_mode = mode; job_fill = fill; job_valid = 1'b1;
        n = 0;
        while (!job_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!job_ready) begin errors++; $display("FAIL accept_timeout: job_ready stuck low"); end
        @(posedge clk); #1;
        job_valid = 1'b0;
        job_num = 4'($urandom); job_amt = 3'($urandom); job_mode = 1'($urandom);
        n = 0;
        while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!res_valid) begin errors++; $display("FAIL result_timeout: res_valid never rose"); end
        got = res_data;
        for (int i = 0; i < hold; i++) begin
            job_valid = pulse && (i == 1);
            @(posedge clk); #1;
        end
        job_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] got;
        #1;
        chk("rst_job_ready", {3'b0, job_ready}, 4'd1);
        chk("rst_res_valid", {3'b0, res_valid}, 4'd0);
        chk("rst_res_data", res_data, 4'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_job(4'b1011, 1, 1'b1, 1'b0, 0, 1'b0, got); chk("rot1", got, 4'b1101);
        do_job(4'b1011, 2, 1'b0, 1'b0, 0, 1'b0, got); chk("log2_f0", got, 4'b0010);
        do_job(4'b1011, 2, 1'b0, 1'b1, 0, 1'b0, got); chk("log2_f1", got, 4'b1110);
        do_job(4'b1011, 0, 1'b1, 1'b0, 0, 1'b0, got); chk("amt0", got, 4'b1011);
        do_job(4'b1011, 5, 1'b1, 1'b0, 0, 1'b0, got); chk("rot5", got, 4'b1101);
        do_job(4'b0110, 7, 1'b0, 1'b0, 0, 1'b0, got); chk("log7_f0", got, 4'b0000);
        do_job(4'b1001, 3, 1'b1, 1'b0, 5, 1'b1, got); chk("backpressure", got, 4'b0011);
        do_job(4'b0101, 1, 1'b0, 1'b1, 0, 1'b0, got); chk("after_bp", got, 4'b1010);
        // Abort an amt=4 job in its second shift cycle.
        @(posedge clk); #1;
        job_num = 4'b1100; job_amt = 3'd4; job_mode = 1'b1; job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("abort_job_ready", {3'b0, job_ready}, 4'd1);
        chk("abort_res_valid", {3'b0, res_valid}, 4'd0);
        chk("abort_sr_load", {3'b0, sr_load}, 4'd0);
        chk("abort_sr_ctrl", {3'b0, sr_ctrl}, 4'd0);
        chk("abort_sr_incoming", {3'b0, sr_incoming}, 4'd0);
        chk("abort_sr_num", sr_num, 4'd0);
        chk("abort_res_data", res_data, 4'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        for (int j = 0; j < 40; j++)
            do_job(4'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), got);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
